// File: rtl/bg_fill_pkg.sv
// bg_fill_pkg: shared constants, FSM state type, command record and the
// full-byte test used by the background fill writer.
// Optional feature macro: BG_FILL_CLEAR_EN (adds the StClr state).
package bg_fill_pkg;

  localparam int unsigned SCREEN_W  = 320;
  localparam int unsigned SCREEN_H  = 240;
  localparam int unsigned ROW_BYTES = 160;
  localparam int unsigned FB_BYTES  = 38400;
  localparam int unsigned ADDR_W    = 16;

`ifdef BG_FILL_CLEAR_EN
  typedef enum logic [2:0] {StIdle, StRow, StRd, StWr, StFin, StClr} fill_state_t;
`else
  typedef enum logic [2:0] {StIdle, StRow, StRd, StWr, StFin} fill_state_t;
`endif

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    logic [8:0] w;
    logic [7:0] h;
    logic [3:0] color;
  } cmd_t;

  // A byte can be written blind only when both of its nibbles are inside the row span.
  function automatic logic is_full(input logic [8:0] col, input logic [8:0] x_end);
    return !col[0] && (({1'b0, col} + 10'd1) < {1'b0, x_end});
  endfunction

endpackage

// File: rtl/bg_fill_writer_if.sv
// bg_fill_writer_if: command handshake plus frame-buffer write-port bundle.
//   master : engine view (takes commands, drives memory strobes, busy/done)
//   slave  : environment view (issues commands, returns read data)
interface bg_fill_writer_if;
  import bg_fill_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [8:0]        cmd_x;
  logic [7:0]        cmd_y;
  logic [8:0]        cmd_w;
  logic [7:0]        cmd_h;
  logic [3:0]        cmd_color;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic              mem_re;
  logic [7:0]        mem_rdata;
  logic              busy;
  logic              done;

  modport master (
    input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, mem_rdata,
    output cmd_ready, mem_addr, mem_we, mem_wdata, mem_re, busy, done
  );

  modport slave (
    output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, mem_rdata,
    input  cmd_ready, mem_addr, mem_we, mem_wdata, mem_re, busy, done
  );

endinterface

// File: rtl/bg_fill_rowaddr.sv
// bg_fill_rowaddr: row-base accumulator and column-to-byte address.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_load, i_y    : load base with y*160 (shift-add, no multiplier)
//   i_step         : advance base by one row (160 bytes)
//   i_col          : current pixel column
//   o_addr         : base + col/2
module bg_fill_rowaddr
  import bg_fill_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [7:0]        i_y,
  input  logic [8:0]        i_col,
  output logic [ADDR_W-1:0] o_addr
);

  localparam logic [ADDR_W-1:0] RowStep = ADDR_W'(ROW_BYTES);

  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] w_y_ext;

  assign w_y_ext = {{(ADDR_W-8){1'b0}}, i_y};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_base <= '0;
    end else if (i_load) begin
      r_base <= (w_y_ext << 7) + (w_y_ext << 5);
    end else if (i_step) begin
      r_base <= r_base + RowStep;
    end
  end

  assign o_addr = r_base + {{(ADDR_W-8){1'b0}}, i_col[8:1]};

endmodule

// File: rtl/bg_fill_writer.sv
// bg_fill_writer: rectangle-fill engine for the 320x240 4-bit background buffer.
// Two pixels per byte (even pixel in [7:4]); edge bytes covering one nibble
// use read-modify-write.
//   i_clk, i_rst_n : clock, async active-low reset (aborts any command)
//   i_clear_req    : whole-buffer clear request (only with BG_FILL_CLEAR_EN)
//   bus            : bg_fill_writer_if.master (command handshake, memory port,
//                    busy, done)
// Optional feature macro: BG_FILL_CLEAR_EN.
module bg_fill_writer
  import bg_fill_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rst_n,
`ifdef BG_FILL_CLEAR_EN
  input  logic                    i_clear_req,
`endif
  bg_fill_writer_if.master        bus
);

  fill_state_t r_state, w_state_d;

  logic [8:0] r_x, w_x_d;
  logic [8:0] r_x_end, w_x_end_d;
  logic [7:0] r_y_end, w_y_end_d;
  logic [7:0] r_row, w_row_d;
  logic [8:0] r_col, w_col_d;
  logic [3:0] r_color, w_color_d;
  logic       r_first, w_first_d;
  logic       r_partial, w_partial_d;
`ifdef BG_FILL_CLEAR_EN
  logic [ADDR_W-1:0] r_clr_addr, w_clr_addr_d;
`endif

  cmd_t       w_cmd;
  logic [9:0] w_x_sum;
  logic [8:0] w_y_sum;
  logic [8:0] w_col_next;
  logic       w_row_load, w_row_step;
  logic [ADDR_W-1:0] w_byte_addr;

  logic              w_cmd_ready;
  logic [ADDR_W-1:0] w_mem_addr;
  logic              w_mem_we;
  logic              w_mem_re;
  logic [7:0]        w_mem_wdata;

  assign w_cmd = '{x: bus.cmd_x, y: bus.cmd_y, w: bus.cmd_w, h: bus.cmd_h,
                   color: bus.cmd_color};

  // Clipped extents; an off-screen origin clips to an empty span.
  assign w_x_sum = {1'b0, w_cmd.x} + {1'b0, w_cmd.w};
  assign w_y_sum = {1'b0, w_cmd.y} + {1'b0, w_cmd.h};

  bg_fill_rowaddr u_rowaddr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_row_load),
    .i_step  (w_row_step),
    .i_y     (r_row),
    .i_col   (r_col),
    .o_addr  (w_byte_addr)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= StIdle;
      r_x       <= '0;
      r_x_end   <= '0;
      r_y_end   <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_color   <= '0;
      r_first   <= 1'b0;
      r_partial <= 1'b0;
`ifdef BG_FILL_CLEAR_EN
      r_clr_addr <= '0;
`endif
    end else begin
      r_state   <= w_state_d;
      r_x       <= w_x_d;
      r_x_end   <= w_x_end_d;
      r_y_end   <= w_y_end_d;
      r_row     <= w_row_d;
      r_col     <= w_col_d;
      r_color   <= w_color_d;
      r_first   <= w_first_d;
      r_partial <= w_partial_d;
`ifdef BG_FILL_CLEAR_EN
      r_clr_addr <= w_clr_addr_d;
`endif
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_x_d       = r_x;
    w_x_end_d   = r_x_end;
    w_y_end_d   = r_y_end;
    w_row_d     = r_row;
    w_col_d     = r_col;
    w_color_d   = r_color;
    w_first_d   = r_first;
    w_partial_d = r_partial;
`ifdef BG_FILL_CLEAR_EN
    w_clr_addr_d = r_clr_addr;
`endif
    w_col_next  = r_col + (r_partial ? 9'd1 : 9'd2);
    w_row_load  = 1'b0;
    w_row_step  = 1'b0;
    w_mem_addr  = '0;
    w_mem_we    = 1'b0;
    w_mem_re    = 1'b0;
    w_mem_wdata = '0;

    unique case (r_state)
      StIdle: begin
`ifdef BG_FILL_CLEAR_EN
        if (i_clear_req) begin
          w_clr_addr_d = '0;
          w_state_d    = StClr;
        end else
`endif
        if (bus.cmd_valid) begin
          w_x_d     = w_cmd.x;
          w_x_end_d = (w_x_sum > 10'(SCREEN_W)) ? 9'(SCREEN_W) : w_x_sum[8:0];
          w_y_end_d = (w_y_sum > 9'(SCREEN_H)) ? 8'(SCREEN_H) : w_y_sum[7:0];
          w_row_d   = w_cmd.y;
          w_color_d = w_cmd.color;
          w_first_d = 1'b1;
          w_state_d = StRow;
        end
      end

      StRow: begin
        // Empty clipped rectangle (w==0, h==0 or off-screen origin) ends here.
        if ((r_x >= r_x_end) || (r_row >= r_y_end)) begin
          w_state_d = StFin;
        end else begin
          w_row_load  = r_first;
          w_row_step  = !r_first;
          w_first_d   = 1'b0;
          w_col_d     = r_x;
          w_partial_d = !is_full(r_x, r_x_end);
          w_state_d   = is_full(r_x, r_x_end) ? StWr : StRd;
        end
      end

      StRd: begin
        w_mem_re   = 1'b1;
        w_mem_addr = w_byte_addr;
        w_state_d  = StWr;
      end

      StWr: begin
        w_mem_we   = 1'b1;
        w_mem_addr = w_byte_addr;
        if (!r_partial) begin
          w_mem_wdata = {r_color, r_color};
        end else if (r_col[0]) begin
          w_mem_wdata = {bus.mem_rdata[7:4], r_color};
        end else begin
          w_mem_wdata = {r_color, bus.mem_rdata[3:0]};
        end
        w_col_d = w_col_next;
        if (w_col_next >= r_x_end) begin
          w_row_d   = r_row + 8'd1;
          w_state_d = ({1'b0, r_row} + 9'd1 >= {1'b0, r_y_end}) ? StFin : StRow;
        end else begin
          w_partial_d = !is_full(w_col_next, r_x_end);
          w_state_d   = is_full(w_col_next, r_x_end) ? StWr : StRd;
        end
      end

`ifdef BG_FILL_CLEAR_EN
      StClr: begin
        w_mem_we     = 1'b1;
        w_mem_addr   = r_clr_addr;
        w_clr_addr_d = r_clr_addr + 1'b1;
        if (r_clr_addr == ADDR_W'(FB_BYTES - 1)) begin
          w_state_d = StFin;
        end
      end
`endif

      StFin: begin
        w_state_d = StIdle;
      end

      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // Gated by reset so every output reads 0 while the engine is held in reset.
`ifdef BG_FILL_CLEAR_EN
  assign w_cmd_ready = i_rst_n && (r_state == StIdle) && !i_clear_req;
`else
  assign w_cmd_ready = i_rst_n && (r_state == StIdle);
`endif

  assign bus.cmd_ready = w_cmd_ready;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_re    = w_mem_re;
  assign bus.mem_wdata = w_mem_wdata;
  assign bus.busy      = (r_state != StIdle);
  assign bus.done      = (r_state == StFin);

endmodule

// File: tb/tb_bg_fill_writer.sv
module tb_bg_fill_writer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear_req = 1'b0;

  always #5 clk = ~clk;

  bg_fill_writer_if bus ();

  bg_fill_writer dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
`ifdef BG_FILL_CLEAR_EN
    .i_clear_req (clear_req),
`endif
    .bus         (bus)
  );

  // Memory model and activity monitors.
  logic [7:0] mem [0:38399];
  logic       pl_en = 1'b0;
  int         pl_addr = 0;
  logic [7:0] pl_data = '0;
  int         n_we = 0, n_re = 0, n_done = 0, n_both = 0, n_nz = 0;
  longint     sum_addr = 0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (bus.mem_we && (int'(bus.mem_addr) < 38400)) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_re && (int'(bus.mem_addr) < 38400)) bus.mem_rdata <= mem[bus.mem_addr];
    if (bus.mem_we) n_we <= n_we + 1;
    if (bus.mem_re) n_re <= n_re + 1;
    if (bus.done) n_done <= n_done + 1;
    if (bus.mem_we && bus.mem_re) n_both <= n_both + 1;
    if (bus.mem_we && bus.mem_wdata != 8'h00) n_nz <= n_nz + 1;
    if (bus.mem_we) sum_addr <= sum_addr + longint'(bus.mem_addr);
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic preload(input int a, input logic [7:0] d);
    @(negedge clk);
    pl_en = 1'b1;
    pl_addr = a;
    pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic drive_cmd(input int x, input int y, input int w, input int h, input int c);
    bus.cmd_x     = 9'(x);
    bus.cmd_y     = 8'(y);
    bus.cmd_w     = 9'(w);
    bus.cmd_h     = 8'(h);
    bus.cmd_color = 4'(c);
  endtask

  function automatic logic [31:0] outs_packed();
    return {bus.cmd_ready, bus.mem_we, bus.mem_re, bus.busy, bus.done,
            bus.mem_wdata, bus.mem_addr};
  endfunction

  typedef struct {
    int x, y, w, h, color;
    int a0, p0, e0;
    int a1, p1, e1;
    int nwe, nre, lat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int we0, re0, dn0, lat;

    bus.cmd_valid = 1'b0;
    drive_cmd(0, 0, 0, 0, 0);
    bus.mem_rdata = '0;

    //       x    y    w    h   c    a0     p0    e0     a1     p1    e1   we re lat
    vecs[0] = '{10,  5,   4,   2,  3,   805,  'h00, 'h33,  966,  'h00, 'h33, 4, 0, 7};
    vecs[1] = '{11,  0,   2,   1,  10,  5,    'h12, 'h1A,  6,    'h12, 'hA2, 2, 2, 6};
    vecs[2] = '{318, 239, 10,  10, 15,  38399,'h00, 'hFF,  38398,'h44, 'h44, 1, 0, 3};
    vecs[3] = '{0,   0,   0,   5,  1,   0,    'h5A, 'h5A,  1,    'h5A, 'h5A, 0, 0, 2};
    vecs[4] = '{0,   0,   3,   2,  5,   1,    'h77, 'h57,  161,  'h77, 'h57, 4, 2, 9};
    vecs[5] = '{1,   2,   1,   1,  9,   320,  'hBC, 'hB9,  321,  'hBC, 'hBC, 1, 1, 4};
    vecs[6] = '{4,   4,   4,   0,  2,   642,  'h66, 'h66,  643,  'h66, 'h66, 0, 0, 2};
    vecs[7] = '{320, 0,   4,   1,  2,   0,    'h11, 'h11,  159,  'h11, 'h11, 0, 0, 2};
    vecs[8] = '{0,   240, 2,   2,  2,   38240,'h22, 'h22,  38399,'h22, 'h22, 0, 0, 2};
    vecs[9] = '{3,   10,  6,   1,  12,  1601, 'h3E, 'h3C,  1604, 'h3E, 'hCE, 4, 2, 8};

    // Reset state.
    repeat (3) @(negedge clk);
    #1 check("reset_outputs_zero", outs_packed(), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_after_release", 32'(bus.cmd_ready), 32'h1);

    for (int i = 0; i < 10; i++) begin
      preload(vecs[i].a0, 8'(vecs[i].p0));
      preload(vecs[i].a1, 8'(vecs[i].p1));
      we0 = n_we; re0 = n_re; dn0 = n_done;
      @(negedge clk);
      drive_cmd(vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h, vecs[i].color);
      bus.cmd_valid = 1'b1;
      #1 check($sformatf("v%0d_ready_idle", i), 32'(bus.cmd_ready), 32'h1);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      #1 check($sformatf("v%0d_ready_held_off", i), 32'(bus.cmd_ready), 32'h0);
      lat = 1;
      while (!bus.done && lat < 200) begin
        @(negedge clk);
        #1 lat++;
      end
      check($sformatf("v%0d_done_latency", i), 32'(lat), 32'(vecs[i].lat));
      @(negedge clk);
      #1 check($sformatf("v%0d_idle_after", i), {31'h0, bus.busy}, 32'h0);
      check($sformatf("v%0d_writes", i), 32'(n_we - we0), 32'(vecs[i].nwe));
      check($sformatf("v%0d_reads", i), 32'(n_re - re0), 32'(vecs[i].nre));
      check($sformatf("v%0d_done_pulses", i), 32'(n_done - dn0), 32'h1);
      check($sformatf("v%0d_byte0", i), 32'(mem[vecs[i].a0]), 32'(vecs[i].e0));
      check($sformatf("v%0d_byte1", i), 32'(mem[vecs[i].a1]), 32'(vecs[i].e1));
    end

    // Reset in the middle of a 100x100 fill aborts with no later writes.
    @(negedge clk);
    drive_cmd(0, 0, 100, 100, 1);
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (30) @(negedge clk);
    #1 check("midrow_writing", 32'(bus.mem_we), 32'h1);
    rst_n = 1'b0;
    #1 check("abort_outputs_zero", outs_packed(), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("abort_ready", 32'(bus.cmd_ready), 32'h1);
    we0 = n_we;
    repeat (20) @(negedge clk);
    check("abort_no_writes", 32'(n_we - we0), 32'h0);
    check("abort_not_busy", 32'(bus.busy), 32'h0);

`ifdef BG_FILL_CLEAR_EN
    begin
      int     nz0;
      longint s0;
      @(negedge clk);
      drive_cmd(0, 0, 2, 1, 7);
      bus.cmd_valid = 1'b1;
      clear_req = 1'b1;
      #1 check("clear_blocks_cmd", 32'(bus.cmd_ready), 32'h0);
      we0 = n_we; re0 = n_re; nz0 = n_nz; s0 = sum_addr;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      clear_req = 1'b0;
      lat = 1;
      while (!bus.done && lat < 40000) begin
        @(negedge clk);
        #1 lat++;
      end
      check("clear_done_latency", 32'(lat), 32'd38401);
      @(negedge clk);
      check("clear_writes", 32'(n_we - we0), 32'd38400);
      check("clear_reads", 32'(n_re - re0), 32'h0);
      check("clear_data_zero", 32'(n_nz - nz0), 32'h0);
      check("clear_addr_sum", 32'(sum_addr - s0), 32'd737260800);
      check("clear_last_byte", 32'(mem[38399]), 32'h0);
    end
`endif

    check("no_we_re_overlap", 32'(n_both), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
